// File: rtl/hazard_ctrl_if.sv
// Hazard bundle between the pipeline and its stall/flush controller.
// Stage status flows in, register hold/bubble/flush controls flow out.
interface hazard_ctrl_if #(
  parameter int RegAddrWidth = 5,
  parameter int STALL_CNT_W  = 32
);
  logic                    ReadMem_EX;
  logic                    WriteReg_EX;
  logic [RegAddrWidth-1:0] target_EX;
  logic [RegAddrWidth-1:0] rs_ID;
  logic [RegAddrWidth-1:0] rt_ID;
  logic                    use_rs_ID;
  logic                    use_rt_ID;
  logic                    div_start_EX;
  logic                    mem_req_MEM;
  logic                    mem_ready;
  logic                    branch_taken_ID;
  logic                    hold_PC;
  logic                    hold_IF_ID;
  logic                    hold_ID_EX;
  logic                    hold_EX_MEM;
  logic                    bubble_ID_EX;
  logic                    bubble_EX_MEM;
  logic                    bubble_MEM_WB;
  logic                    flush_IF_ID;
  logic                    div_busy;
  logic                    div_done;
  logic [STALL_CNT_W-1:0]  stall_count;

  modport slave (
    input  ReadMem_EX, WriteReg_EX, target_EX,
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID,
    input  div_start_EX, mem_req_MEM, mem_ready,
    input  branch_taken_ID,
    output hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM,
    output bubble_ID_EX, bubble_EX_MEM, bubble_MEM_WB,
    output flush_IF_ID, div_busy, div_done, stall_count
  );

  modport master (
    output ReadMem_EX, WriteReg_EX, target_EX,
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID,
    output div_start_EX, mem_req_MEM, mem_ready,
    output branch_taken_ID,
    input  hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM,
    input  bubble_ID_EX, bubble_EX_MEM, bubble_MEM_WB,
    input  flush_IF_ID, div_busy, div_done, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: mem wait > divide > load-use > flush.
// Stall decisions are combinational; only FSM, divide count, stall count are state.
module hazard_ctrl #(
  parameter int RegAddrWidth = 5,
  parameter int DIV_CYCLES   = 32,
  parameter int CNT_W        = 6,
  parameter int STALL_CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, DIV} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [STALL_CNT_W-1:0] stall_count;

  logic mem_stall;
  logic rs_hit;
  logic rt_hit;
  logic lu_stall;
  logic div_hold;
  logic act_mem;
  logic act_div;
  logic act_done;
  logic act_lu;

  logic hold_pc;
  logic hold_if_id;
  logic hold_id_ex;
  logic hold_ex_mem;
  logic bubble_id_ex;
  logic bubble_ex_mem;
  logic bubble_mem_wb;
  logic flush_if_id;
  logic div_busy;
  logic div_done;

  // Raw hazard terms from the stage status.
  always_comb begin
    mem_stall = hz.mem_req_MEM & ~hz.mem_ready;
    rs_hit    = hz.use_rs_ID & (hz.rs_ID == hz.target_EX);
    rt_hit    = hz.use_rt_ID & (hz.rt_ID == hz.target_EX);
    lu_stall  = hz.ReadMem_EX & hz.WriteReg_EX
              & (hz.target_EX != RegAddrWidth'(0))
              & (rs_hit | rt_hit);
    div_hold  = ((state == RUN) & hz.div_start_EX)
              | ((state == DIV) & (cnt != '0));
  end

  // Priority-resolved, mutually exclusive action classes.
  always_comb begin
    act_mem  = mem_stall;
    act_div  = div_hold & ~mem_stall;
    act_done = (state == DIV) & (cnt == '0) & ~mem_stall;
    act_lu   = lu_stall & (state == RUN)
             & ~hz.div_start_EX & ~mem_stall;
  end

  // Per-register hold/bubble/flush controls, all forced low in reset.
  always_comb begin
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    hold_id_ex    = 1'b0;
    hold_ex_mem   = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    bubble_mem_wb = 1'b0;
    flush_if_id   = 1'b0;
    div_done      = 1'b0;
    div_busy      = rst & (state == DIV);
    if (rst) begin
      unique case (1'b1)
        act_mem: begin
          hold_pc       = 1'b1;
          hold_if_id    = 1'b1;
          hold_id_ex    = 1'b1;
          hold_ex_mem   = 1'b1;
          bubble_mem_wb = 1'b1;
        end
        act_div: begin
          hold_pc       = 1'b1;
          hold_if_id    = 1'b1;
          hold_id_ex    = 1'b1;
          bubble_ex_mem = 1'b1;
        end
        act_done: begin
          div_done = 1'b1;
        end
        act_lu: begin
          hold_pc      = 1'b1;
          hold_if_id   = 1'b1;
          bubble_id_ex = 1'b1;
        end
        default: begin
          flush_if_id = hz.branch_taken_ID;
        end
      endcase
    end
  end

  // Divide occupancy FSM; a start seen under a mem wait is deferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.div_start_EX & ~mem_stall) begin
            state <= DIV;
            cnt   <= CNT_W'(DIV_CYCLES - 2);
          end
        end
        DIV: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (~mem_stall) begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  // Performance counter of cycles the PC was frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (hold_pc) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  assign hz.hold_PC       = hold_pc;
  assign hz.hold_IF_ID    = hold_if_id;
  assign hz.hold_ID_EX    = hold_id_ex;
  assign hz.hold_EX_MEM   = hold_ex_mem;
  assign hz.bubble_ID_EX  = bubble_id_ex;
  assign hz.bubble_EX_MEM = bubble_ex_mem;
  assign hz.bubble_MEM_WB = bubble_mem_wb;
  assign hz.flush_IF_ID   = flush_if_id;
  assign hz.div_busy      = div_busy;
  assign hz.div_done      = div_done;
  assign hz.stall_count   = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int D = 4;

  // Output vector order:
  // hold_PC hold_IF_ID hold_ID_EX hold_EX_MEM
  // bubble_ID_EX bubble_EX_MEM bubble_MEM_WB flush busy done
  localparam logic [9:0] V_LU   = 10'b1100100000;
  localparam logic [9:0] V_DIV  = 10'b1110010000;
  localparam logic [9:0] V_MEM  = 10'b1111001000;
  localparam logic [9:0] V_FL   = 10'b0000000100;
  localparam logic [9:0] V_BUSY = 10'b0000000010;
  localparam logic [9:0] V_DONE = 10'b0000000001;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_sc;

  hazard_ctrl_if #(.RegAddrWidth(5), .STALL_CNT_W(32)) hz ();

  hazard_ctrl #(
    .RegAddrWidth(5),
    .DIV_CYCLES  (D),
    .CNT_W       (6),
    .STALL_CNT_W (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {hz.hold_PC, hz.hold_IF_ID, hz.hold_ID_EX,
            hz.hold_EX_MEM, hz.bubble_ID_EX, hz.bubble_EX_MEM,
            hz.bubble_MEM_WB, hz.flush_IF_ID, hz.div_busy,
            hz.div_done};
  endfunction

  task automatic idle();
    hz.ReadMem_EX      = 1'b0;
    hz.WriteReg_EX     = 1'b0;
    hz.target_EX       = '0;
    hz.rs_ID           = '0;
    hz.rt_ID           = '0;
    hz.use_rs_ID       = 1'b0;
    hz.use_rt_ID       = 1'b0;
    hz.div_start_EX    = 1'b0;
    hz.mem_req_MEM     = 1'b0;
    hz.mem_ready       = 1'b0;
    hz.branch_taken_ID = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic wr, input logic [4:0] tg,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    hz.ReadMem_EX  = 1'b1;
    hz.WriteReg_EX = wr;
    hz.target_EX   = tg;
    hz.rs_ID       = rs;
    hz.use_rs_ID   = urs;
    hz.rt_ID       = rt;
    hz.use_rt_ID   = urt;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    hz.mem_req_MEM     = 1'b1;
    hz.branch_taken_ID = 1'b1;
    hz.div_start_EX    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL reset_out got=%b want=%b", obs(), 10'b0);
    end
    checks++;
    if (hz.stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_sc got=%0d want=0", hz.stall_count);
    end
    idle();
    rst = 1'b1;
    exp_sc = 32'd0;
    tick();
    @(negedge clk);
    checks++;
    if (obs() !== 10'b0 || hz.stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle got=%b/%0d want=0/0",
               obs(), hz.stall_count);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [9:0] want [5];
    want = '{V_LU, 10'b0, V_LU, 10'b0, 10'b0};
    for (int k = 0; k < 5; k++) begin
      idle();
      case (k)
        0: set_lu(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        1: set_lu(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        2: set_lu(1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b1);
        3: set_lu(1'b1, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
        default: set_lu(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
      endcase
      @(negedge clk);
      checks++;
      if (obs() !== want[k]) begin
        errors++;
        $display("FAIL load_use_%0d got=%b want=%b",
                 k, obs(), want[k]);
      end
      checks++;
      if (hz.stall_count !== exp_sc) begin
        errors++;
        $display("FAIL load_use_sc_%0d got=%0d want=%0d",
                 k, hz.stall_count, exp_sc);
      end
      tick();
      exp_sc += 32'(want[k][9]);
      idle();
    end
    @(negedge clk);
    checks++;
    if (hz.stall_count !== 32'd2) begin
      errors++;
      $display("FAIL load_use_total got=%0d want=2", hz.stall_count);
    end
    tick();
  endtask

  task automatic test_divide();
    logic [9:0] e;
    idle();
    hz.div_start_EX = 1'b1;
    for (int c = 1; c <= D; c++) begin
      if (c < D) e = V_DIV | ((c > 1) ? V_BUSY : 10'b0);
      else e = V_BUSY | V_DONE;
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL divide_c%0d got=%b want=%b", c, obs(), e);
      end
      tick();
      exp_sc += 32'(e[9]);
      if (c == D) idle();
    end
    @(negedge clk);
    checks++;
    if (obs() !== 10'b0 || hz.stall_count !== exp_sc) begin
      errors++;
      $display("FAIL divide_after got=%b/%0d want=0/%0d",
               obs(), hz.stall_count, exp_sc);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [31:0] sc0;
    logic [9:0]  e;
    sc0 = exp_sc;
    idle();
    hz.mem_req_MEM     = 1'b1;
    hz.branch_taken_ID = 1'b1;
    for (int c = 0; c < 4; c++) begin
      hz.mem_ready = (c == 3);
      e = (c < 3) ? V_MEM : V_FL;
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL mem_wait_c%0d got=%b want=%b", c, obs(), e);
      end
      tick();
      exp_sc += 32'(e[9]);
    end
    idle();
    @(negedge clk);
    checks++;
    if (hz.stall_count !== sc0 + 32'd3) begin
      errors++;
      $display("FAIL mem_wait_sc got=%0d want=%0d",
               hz.stall_count, sc0 + 32'd3);
    end
    tick();
  endtask

  task automatic test_div_mem_overlap();
    logic [9:0] e;
    idle();
    hz.div_start_EX = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      hz.mem_req_MEM = (c >= 3 && c <= 6);
      hz.mem_ready   = 1'b0;
      if (c == 1) e = V_DIV;
      else if (c == 2) e = V_DIV | V_BUSY;
      else if (c <= 6) e = V_MEM | V_BUSY;
      else e = V_DONE | V_BUSY;
      @(negedge clk);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL div_mem_c%0d got=%b want=%b", c, obs(), e);
      end
      tick();
      exp_sc += 32'(e[9]);
    end
    idle();
    @(negedge clk);
    checks++;
    if (obs() !== 10'b0 || hz.stall_count !== exp_sc) begin
      errors++;
      $display("FAIL div_mem_after got=%b/%0d want=0/%0d",
               obs(), hz.stall_count, exp_sc);
    end
    tick();
  endtask

  task automatic test_branch_stall();
    idle();
    set_lu(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    hz.branch_taken_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== V_LU) begin
      errors++;
      $display("FAIL branch_in_lu got=%b want=%b", obs(), V_LU);
    end
    tick();
    exp_sc += 32'd1;
    idle();
    hz.branch_taken_ID = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== V_FL) begin
      errors++;
      $display("FAIL branch_after got=%b want=%b", obs(), V_FL);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_div();
    idle();
    hz.div_start_EX = 1'b1;
    tick();
    exp_sc += 32'd1;
    @(negedge clk);
    checks++;
    if (obs() !== (V_DIV | V_BUSY)) begin
      errors++;
      $display("FAIL rst_div_pre got=%b want=%b",
               obs(), V_DIV | V_BUSY);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 10'b0 || hz.stall_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_async got=%b/%0d want=0/0",
               obs(), hz.stall_count);
    end
    tick();
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL rst_hold got=%b want=0", obs());
    end
    idle();
    rst = 1'b1;
    exp_sc = 32'd0;
    tick();
    test_divide();
  endtask

  task automatic test_random();
    logic       ms, lu, dh, dn, in_div;
    int         el;
    logic [9:0] e;
    in_div = 1'b0;
    el     = 0;
    for (int i = 0; i < 500; i++) begin
      hz.ReadMem_EX      = 1'($urandom_range(1));
      hz.WriteReg_EX     = 1'($urandom_range(3) != 0);
      hz.target_EX       = 5'($urandom_range(3));
      hz.rs_ID           = 5'($urandom_range(3));
      hz.rt_ID           = 5'($urandom_range(3));
      hz.use_rs_ID       = 1'($urandom_range(1));
      hz.use_rt_ID       = 1'($urandom_range(1));
      hz.div_start_EX    = 1'($urandom_range(7) == 0);
      hz.mem_req_MEM     = 1'($urandom_range(2) == 0);
      hz.mem_ready       = 1'($urandom_range(1));
      hz.branch_taken_ID = 1'($urandom_range(1));
      ms = hz.mem_req_MEM && !hz.mem_ready;
      lu = hz.ReadMem_EX && hz.WriteReg_EX && hz.target_EX != 0
        && ((hz.use_rs_ID && hz.rs_ID == hz.target_EX)
         || (hz.use_rt_ID && hz.rt_ID == hz.target_EX));
      dh = in_div ? (el < D - 1) : hz.div_start_EX;
      dn = in_div && el >= D - 1 && !ms;
      if (ms) e = V_MEM;
      else if (dh) e = V_DIV;
      else if (dn) e = V_DONE;
      else if (lu) e = V_LU;
      else if (hz.branch_taken_ID) e = V_FL;
      else e = 10'b0;
      if (in_div) e = e | V_BUSY;
      @(negedge clk);
      checks++;
      if (obs() !== e || hz.stall_count !== exp_sc) begin
        errors++;
        $display("FAIL random_%0d got=%b/%0d want=%b/%0d",
                 i, obs(), hz.stall_count, e, exp_sc);
      end
      tick();
      exp_sc += 32'(e[9]);
      if (!in_div) begin
        if (hz.div_start_EX && !ms) begin
          in_div = 1'b1;
          el     = 1;
        end
      end else if (dn) begin
        in_div = 1'b0;
      end else begin
        el++;
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_div_mem_overlap();
    test_branch_stall();
    test_reset_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
